// File: rtl/fifo_read_drain.sv
// fifo_read_drain: FIFO read-side drain absorbing one-cycle read latency into a 2-entry skid buffer.
module fifo_read_drain #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Enable_in,
  input  logic                   Flush_in,
  input  logic                   Fifo_Empty_in,
  output logic                   Fifo_ReadEn_out,
  input  logic [DATA_WIDTH-1:0]  Fifo_Data_in,
  output logic [DATA_WIDTH-1:0]  Data_out,
  output logic                   Valid_out,
  input  logic                   Ready_in,
  output logic                   Busy_out,
  output logic [COUNT_WIDTH-1:0] Word_count_out
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t state, state_nxt;
  logic [1:0] occ, pending;
  logic inflight, pop, flushing;
  logic [DATA_WIDTH-1:0] head, tail;
  logic [COUNT_WIDTH-1:0] count;
  assign pending = occ + {1'b0, inflight};
  assign flushing = Flush_in || state == FLUSH;
  assign Data_out = head;
  assign Word_count_out = count;
  assign Busy_out = occ != 2'd0 || inflight || state == FLUSH;
  // A read is only issued when its word is guaranteed a skid slot on landing.
  always_comb begin
    Valid_out = occ != 2'd0 && state != FLUSH && !Flush_in;
    pop = Valid_out && Ready_in;
    Fifo_ReadEn_out = state == RUN && Enable_in && !Flush_in && !Fifo_Empty_in &&
                      (pending <= 2'd1 || (pending == 2'd2 && pop));
    state_nxt = Flush_in ? FLUSH : state == FLUSH ? (inflight ? FLUSH : IDLE) : Enable_in ? RUN : IDLE;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      occ      <= 2'd0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= Fifo_ReadEn_out;
      count    <= count + COUNT_WIDTH'(pop);
      if (flushing) occ <= 2'd0;
      else begin
        occ <= occ + {1'b0, inflight} - {1'b0, pop};
        if (pop && occ == 2'd2) head <= tail;
        else if (inflight && (occ == 2'd0 || (occ == 2'd1 && pop))) head <= Fifo_Data_in;
        if (inflight && occ == 2'd1 && !pop) tail <= Fifo_Data_in;
      end
    end
  end
endmodule

// File: tb/tb_fifo_read_drain.sv
// tb_fifo_read_drain: directed checks of fifo_read_drain against a behavioural FIFO with registered read data.
module tb_fifo_read_drain;
  logic clk = 0, rst_n = 0, enable = 0, flush = 0, ready = 1;
  logic fifo_empty, read_en, valid, busy;
  logic [31:0] fifo_data = '0, data;
  logic [15:0] count;
  logic [31:0] mem [0:65599];
  logic [31:0] got [$];
  logic [11:0] vpat;
  logic prev_stall = 0;
  logic [31:0] prev_data = '0;
  int wr = 0, rd = 0, total = 0, bad = 0;

  fifo_read_drain dut (
    .Clk(clk), .Reset_n(rst_n), .Enable_in(enable), .Flush_in(flush),
    .Fifo_Empty_in(fifo_empty), .Fifo_ReadEn_out(read_en), .Fifo_Data_in(fifo_data),
    .Data_out(data), .Valid_out(valid), .Ready_in(ready), .Busy_out(busy),
    .Word_count_out(count)
  );

  always #5 clk = ~clk;
  assign fifo_empty = (rd == wr);
  always @(posedge clk) if (read_en) begin
    fifo_data <= mem[rd];
    rd <= rd + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick; @(negedge clk); endtask
  task automatic push(input logic [31:0] v); mem[wr] = v; wr++; endtask
  task automatic wait_got(input int n, input int lim);
    for (int i = 0; i < lim && got.size() < n; i++) tick();
  endtask

  // Per-cycle monitor: scoreboard capture plus invariants.
  always begin
    @(negedge clk); #2;
    chk("read_while_empty", 32'(read_en & fifo_empty), 32'd0);
    chk("occ_inflight_bound", 32'(32'(dut.occ) + 32'(dut.inflight) <= 32'd2), 32'd1);
    if (prev_stall && valid) chk("stall_hold", data, prev_data);
    if (valid && ready) got.push_back(data);
    prev_stall = valid && !ready;
    prev_data = data;
  end

  initial begin
    tick(); tick(); #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", data, 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_rden", 32'(read_en), 0);
    chk("rst_busy", 32'(busy), 0);
    tick(); rst_n = 1;
    tick(); enable = 1;
    tick(); push(32'hA5A5A5A5); #1;
    chk("t1_rden", 32'(read_en), 1);
    tick(); #1;
    chk("t1_rden_pulse", 32'(read_en), 0);
    chk("t1_valid_early", 32'(valid), 0);
    tick(); #1;
    chk("t1_valid", 32'(valid), 1);
    chk("t1_data", data, 32'hA5A5A5A5);
    chk("t1_count_before", 32'(count), 0);
    tick(); #1;
    chk("t1_count", 32'(count), 1);
    chk("t1_valid_off", 32'(valid), 0);

    tick();
    for (int i = 0; i < 8; i++) push(32'(i));
    #1; vpat[0] = valid;
    for (int k = 1; k < 12; k++) begin tick(); #1; vpat[k] = valid; end
    chk("t2_valid_pattern", 32'(vpat), 32'h3FC);
    chk("t2_count", 32'(count), 9);
    chk("t2_got_size", 32'(got.size()), 9);
    for (int i = 0; i < 8; i++) chk("t2_data", got[1+i], 32'(i));

    for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
    for (int c = 0; c < 120 && got.size() < 25; c++) begin
      ready = (c % 4 == 0) || (c % 4 == 3);
      tick();
    end
    ready = 1;
    repeat (5) tick();
    #1;
    chk("t3_got_size", 32'(got.size()), 25);
    chk("t3_busy", 32'(busy), 0);
    for (int i = 0; i < 16; i++) chk("t3_data", got[9+i], 32'h100 + 32'(i));

    tick(); ready = 0;
    for (int i = 0; i < 4; i++) push(32'hC8 + 32'(i));
    repeat (4) tick();
    #1;
    chk("t4_full_valid", 32'(valid), 1);
    chk("t4_full_data", data, 32'hC8);
    chk("t4_full_rden", 32'(read_en), 0);
    tick(); flush = 1; ready = 1; #1;
    chk("t4_flush_valid", 32'(valid), 0);
    chk("t4_flush_rden", 32'(read_en), 0);
    tick(); #1;
    chk("t4_flush_busy", 32'(busy), 1);
    chk("t4_flush_valid2", 32'(valid), 0);
    tick(); flush = 0; #1;
    chk("t4_release_busy", 32'(busy), 1);
    tick(); #1;
    chk("t4_idle_busy", 32'(busy), 0);
    chk("t4_count", 32'(count), 25);
    wait_got(27, 20);
    chk("t4_got_size", 32'(got.size()), 27);
    chk("t4_next_word", got[25], 32'hCA);
    chk("t4_next_word2", got[26], 32'hCB);

    tick(); #1;
    tick();
    for (int i = 0; i < 3; i++) push(32'h12C + 32'(i));
    #1;
    chk("t5_rden", 32'(read_en), 1);
    tick(); enable = 0; #1;
    chk("t5_rden_off", 32'(read_en), 0);
    tick(); #1;
    chk("t5_inflight_valid", 32'(valid), 1);
    chk("t5_inflight_data", data, 32'h12C);
    repeat (3) tick();
    #1;
    chk("t5_stopped_valid", 32'(valid), 0);
    chk("t5_stopped_rden", 32'(read_en), 0);
    chk("t5_got_size", 32'(got.size()), 28);
    tick(); enable = 1;
    wait_got(30, 20);
    chk("t5_resume_size", 32'(got.size()), 30);
    chk("t5_resume_data", got[28], 32'h12D);
    chk("t5_resume_data2", got[29], 32'h12E);

    tick();
    for (int i = 0; i < 65505; i++) push(32'(i));
    wait_got(65535, 65600);
    tick(); #1;
    chk("t6_bulk_size", 32'(got.size()), 65535);
    chk("t6_count_max", 32'(count), 32'hFFFF);
    chk("t6_bulk_busy", 32'(busy), 0);
    push(32'hDEADBEEF);
    wait_got(65536, 20);
    #1;
    chk("t6_count_wrap", 32'(count), 0);
    chk("t6_wrap_data", got[65535], 32'hDEADBEEF);
    tick();
    for (int i = 0; i < 10; i++) push(32'h5000 + 32'(i));
    repeat (4) tick();
    #1;
    chk("t6_midburst_valid", 32'(valid), 1);
    #2; rst_n = 0; #1;
    chk("t6_rst_valid", 32'(valid), 0);
    chk("t6_rst_count", 32'(count), 0);
    chk("t6_rst_rden", 32'(read_en), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_data", data, 0);
    tick(); rst_n = 1;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
